// File: rtl/fixed_point_accumulator.sv
// rtl/fixed_point_accumulator.sv - saturating accumulator of N_TERMS multiplier products
//
// Captures one product on each rising edge of in_valid (the multiplier's level
// finish signal) and adds it into a saturating two's-complement sum. After
// N_TERMS products the block raises done and ignores further products until
// clear or rst.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset, overrides everything
//   clear         synchronous restart of the accumulation (drops a coincident term)
//   in_value      product from the multiplier
//   in_overflow   multiplier overflow flag for in_value
//   in_valid      multiplier finish (level); only its rising edge is a term
//   sum           running / final saturated sum
//   overflow_flag sticky: any input overflow or saturation since clear/rst
//   count         terms accepted since clear/rst
//   done          N_TERMS terms accepted; held until clear/rst
module fixed_point_accumulator #(
  parameter int WIDTH   = 16,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_overflow,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             overflow_flag,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(N_TERMS);
  localparam logic [WIDTH-1:0] LP_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LP_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prev_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  logic             w_event;
  logic [WIDTH:0]   w_sum_ext;
  logic             w_pos_sat;
  logic             w_neg_sat;
  logic [WIDTH-1:0] w_sat_sum;
  logic [CNT_W-1:0] w_count_inc;

  // A held-high finish counts once: only the 0->1 transition is a term.
  assign w_event = in_valid & ~r_prev_valid;

  // One guard bit is enough: the two sign bits disagree exactly on overflow.
  assign w_sum_ext = {r_sum[WIDTH-1], r_sum} + {in_value[WIDTH-1], in_value};
  assign w_pos_sat = ~w_sum_ext[WIDTH] &  w_sum_ext[WIDTH-1];
  assign w_neg_sat =  w_sum_ext[WIDTH] & ~w_sum_ext[WIDTH-1];

  always_comb begin
    w_sat_sum = w_sum_ext[WIDTH-1:0];
    if (w_pos_sat) begin
      w_sat_sum = LP_MAX_POS;
    end else if (w_neg_sat) begin
      w_sat_sum = LP_MAX_NEG;
    end
  end

  assign w_count_inc = r_count + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_ovf_nxt   = r_ovf;
    w_count_nxt = r_count;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
      w_sum_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_event) begin
            w_sum_nxt   = w_sat_sum;
            w_count_nxt = w_count_inc;
            w_ovf_nxt   = r_ovf | in_overflow | w_pos_sat | w_neg_sat;
            if (w_count_inc == LP_LAST) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACCUM;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_count      <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sum        <= w_sum_nxt;
      r_ovf        <= w_ovf_nxt;
      r_count      <= w_count_nxt;
      // Tracks in_valid in every state, including during clear.
      r_prev_valid <= in_valid;
    end
  end

  assign sum           = r_sum;
  assign overflow_flag = r_ovf;
  assign count         = r_count;
  assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb/tb_fixed_point_accumulator.sv - self-checking bench for fixed_point_accumulator
module tb_fixed_point_accumulator;

  localparam int WIDTH   = 16;
  localparam int N_TERMS = 4;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst;
  logic             clear;
  logic [WIDTH-1:0] in_value;
  logic             in_overflow;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             overflow_flag;
  logic [CNT_W-1:0] count;
  logic             done;

  fixed_point_accumulator #(
    .WIDTH  (WIDTH),
    .N_TERMS(N_TERMS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_value     (in_value),
    .in_overflow  (in_overflow),
    .in_valid     (in_valid),
    .sum          (sum),
    .overflow_flag(overflow_flag),
    .count        (count),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain integer arithmetic with clamping.
  logic [WIDTH-1:0] m_sum;
  logic             m_ovf;
  int               m_cnt;
  logic             m_done;
  logic             m_prev;
  logic             m_live = 1'b0;
  int               m_s;
  logic             m_sat;

  always @(posedge clk) begin
    if (rst) begin
      m_sum  = '0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      m_prev = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (clear) begin
        m_sum  = '0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        m_done = 1'b0;
      end else if (in_valid && !m_prev && !m_done) begin
        m_s   = int'($signed(m_sum)) + int'($signed(in_value));
        m_sat = 1'b0;
        if (m_s > 32767) begin
          m_s   = 32767;
          m_sat = 1'b1;
        end else if (m_s < -32768) begin
          m_s   = -32768;
          m_sat = 1'b1;
        end
        m_sum = WIDTH'(m_s);
        m_cnt = m_cnt + 1;
        m_ovf = m_ovf | in_overflow | m_sat;
        if (m_cnt == N_TERMS) m_done = 1'b1;
      end
      m_prev = in_valid;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with the given inputs, then compare every output to the model.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [WIDTH-1:0] val, input logic ov);
    rst         = r;
    clear       = c;
    in_valid    = v;
    in_value    = val;
    in_overflow = ov;
    @(posedge clk);
    #1;
    if (m_live) begin
      chk("cyc_sum",   32'(sum),           32'(m_sum));
      chk("cyc_ovf",   32'(overflow_flag), 32'(m_ovf));
      chk("cyc_count", 32'(count),         32'(m_cnt));
      chk("cyc_done",  32'(done),          32'(m_done));
    end
  endtask

  task automatic pulse(input logic [WIDTH-1:0] val, input logic ov);
    cyc(1'b0, 1'b0, 1'b1, val, ov);
    cyc(1'b0, 1'b0, 1'b0, val, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [WIDTH-1:0] t1_vals [4];
  logic [WIDTH-1:0] t1_exp  [4];
  logic             r_v;
  logic [WIDTH-1:0] r_val;
  int               sel;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_value = '0; in_overflow = 1'b0;

    // Reset state
    do_reset();
    chk("rst_sum",   32'(sum),           32'h0);
    chk("rst_count", 32'(count),         32'h0);
    chk("rst_done",  32'(done),          32'h0);
    chk("rst_ovf",   32'(overflow_flag), 32'h0);

    // Plain four-term sum
    t1_vals = '{16'h0100, 16'h0200, 16'hFF00, 16'h0010};
    t1_exp  = '{16'h0100, 16'h0300, 16'h0200, 16'h0210};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, t1_vals[i], 1'b0);
      chk("t1_sum", 32'(sum), 32'(t1_exp[i]));
      chk("t1_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_ovf", 32'(overflow_flag), 32'h0);
    chk("t1_model_sum", 32'(m_sum), 32'h0210);

    // Events after done are ignored
    pulse(16'h1234, 1'b1);
    pulse(16'h0001, 1'b0);
    chk("t5_hold_sum", 32'(sum), 32'h0210);
    chk("t5_hold_count", 32'(count), 32'd4);
    chk("t5_hold_done", 32'(done), 32'h1);
    chk("t5_hold_ovf", 32'(overflow_flag), 32'h0);

    // clear coincident with an in_valid rise drops that term
    cyc(1'b0, 1'b1, 1'b1, 16'h0055, 1'b0);
    chk("t5_clr_sum", 32'(sum), 32'h0);
    chk("t5_clr_count", 32'(count), 32'h0);
    chk("t5_clr_done", 32'(done), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
    chk("t5_noreaccept", 32'(count), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Positive saturation then recovery
    pulse(16'h4000, 1'b0);
    pulse(16'h4000, 1'b0);
    chk("t2_sat_sum", 32'(sum), 32'h7FFF);
    chk("t2_sat_ovf", 32'(overflow_flag), 32'h1);
    pulse(16'hC000, 1'b0);
    chk("t2_mid_sum", 32'(sum), 32'h3FFF);
    pulse(16'h0001, 1'b0);
    chk("t2_final_sum", 32'(sum), 32'h4000);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_ovf_sticky", 32'(overflow_flag), 32'h1);
    chk("t2_model_sum", 32'(m_sum), 32'h4000);

    // Held-high finish counts once
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    pulse(16'h0003, 1'b0);
    chk("t3_count", 32'(count), 32'd2);
    chk("t3_sum", 32'(sum), 32'h0008);
    chk("t3_done", 32'(done), 32'h0);

    // Negative saturation, then an input flagged as overflowed
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    pulse(16'h8001, 1'b0);
    pulse(16'hFFFE, 1'b0);
    chk("t4_neg_sum", 32'(sum), 32'h8000);
    chk("t4_neg_ovf", 32'(overflow_flag), 32'h1);
    pulse(16'h0001, 1'b1);
    chk("t4_inovf_sum", 32'(sum), 32'h8001);
    chk("t4_inovf_flag", 32'(overflow_flag), 32'h1);
    chk("t4_count", 32'(count), 32'd3);

    // rst mid-accumulation with a coincident in_valid rise
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    pulse(16'h0011, 1'b1);
    pulse(16'h0022, 1'b0);
    chk("t6_pre_count", 32'(count), 32'd2);
    cyc(1'b1, 1'b0, 1'b1, 16'h0099, 1'b0);
    chk("t6_rst_sum", 32'(sum), 32'h0);
    chk("t6_rst_count", 32'(count), 32'h0);
    chk("t6_rst_ovf", 32'(overflow_flag), 32'h0);
    chk("t6_rst_done", 32'(done), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    pulse(16'h0007, 1'b0);
    chk("t6_sum", 32'(sum), 32'h0007);
    chk("t6_count", 32'(count), 32'd1);

    // in_valid held high through rst counts on the first cycle after it
    cyc(1'b1, 1'b0, 1'b1, 16'h0009, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0009, 1'b0);
    chk("t7_first_after_rst", 32'(count), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic against the model
    r_v = 1'b0;
    r_val = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r_v = ~r_v;
        sel = $urandom_range(0, 3);
        case (sel)
          0:       r_val = WIDTH'($urandom);
          1:       r_val = WIDTH'($urandom_range(0, 255));
          2:       r_val = 16'h7000 + WIDTH'($urandom_range(0, 4095));
          default: r_val = 16'h8000 + WIDTH'($urandom_range(0, 4095));
        endcase
      end
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), r_v, r_val,
          ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
